// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit for the E stage of the
// five-stage MIPS pipeline.
// - Asks the hazard unit to stall while an operation is in flight.
// - Aborts when flushE kills the E-stage op.
// - Writes HI/LO with a one-cycle strobe in the DONE state.
// Optional build macro MULDIV_EARLY_OUT_EN: a DIV/DIVU with a zero divisor,
// or with |a| < |b|, skips the iteration loop and goes straight to DONE.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flushE,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, nextState;
  logic [5:0]         cnt;

  // Acceptance-cycle decode of the incoming operands
  logic               accept;
  logic               isSignedIn, aNegIn, bNegIn, earlyOut;
  logic signed [31:0] aSgn, bSgn;
  logic [31:0]        aMagIn, bMagIn;

  // Operation context latched at acceptance
  logic               isDiv, negP, negQ, negR, divZero;
  logic [31:0]        aRaw, aMag, bMag;
  logic signed [63:0] prodReg;
  logic [31:0]        quoReg, remReg;
  logic [32:0]        remShift, remDiff;

  // Sign fix-up and divide-by-zero override of the magnitude division.
  // The 0x8000_0000 / -1 case needs no special path. Its magnitude
  // quotient is 0x8000_0000, and the signs cancel, so the result is
  // already the required lo=0x8000_0000, hi=0.
  function automatic logic [63:0] divFixup(
    input logic [31:0] q,
    input logic [31:0] r,
    input logic        nq,
    input logic        nr,
    input logic        dz,
    input logic [31:0] dividend
  );
    logic [31:0] qOut, rOut;
    qOut = nq ? (~q + 32'd1) : q;
    rOut = nr ? (~r + 32'd1) : r;
    if (dz) return {dividend, 32'hFFFF_FFFF};
    return {rOut, qOut};
  endfunction

  assign accept     = (state == IDLE) && start && !flushE;
  assign isSignedIn = !op[0];
  assign aSgn       = a;
  assign bSgn       = b;
  assign aNegIn     = isSignedIn && (aSgn < 0);
  assign bNegIn     = isSignedIn && (bSgn < 0);
  assign aMagIn     = aNegIn ? (~a + 32'd1) : a;
  assign bMagIn     = bNegIn ? (~b + 32'd1) : b;

`ifdef MULDIV_EARLY_OUT_EN
  assign earlyOut = op[1] && ((b == 32'd0) || (aMagIn < bMagIn));
`else
  assign earlyOut = 1'b0;
`endif

  // One restoring-division step: shift in the next dividend bit, then trial-subtract
  assign remShift = {remReg, quoReg[31]};
  assign remDiff  = remShift - {1'b0, bMag};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic; flushE aborts any in-flight op
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = earlyOut ? DONE : (op[1] ? DIV : MUL);
      MUL:  if (flushE) nextState = IDLE;
            else if (cnt == 6'd1) nextState = DONE;
      DIV:  if (flushE) nextState = IDLE;
            else if (cnt == 6'd31) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs: combinational stall so the hazard unit sees it in the acceptance cycle
  always_comb begin
    stall_req = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      IDLE:    stall_req = start && !flushE;
      MUL,
      DIV:     stall_req = 1'b1;
      DONE:    hilo_we   = !flushE;
      default: ;
    endcase
  end

  // Iteration counter; restarts from zero whenever the unit is not iterating
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              cnt <= 6'd0;
    else if ((state == MUL) || (state == DIV)) cnt <= cnt + 6'd1;
    else                                    cnt <= 6'd0;
  end

  // Datapath: latch operands on acceptance, then multiply or divide
  always_ff @(posedge clk) begin
    if (accept) begin
      isDiv   <= op[1];
      negP    <= aNegIn ^ bNegIn;
      negQ    <= aNegIn ^ bNegIn;
      negR    <= aNegIn;
      divZero <= (b == 32'd0);
      aRaw    <= a;
      aMag    <= aMagIn;
      bMag    <= bMagIn;
      quoReg  <= earlyOut ? 32'd0  : aMagIn;
      remReg  <= earlyOut ? aMagIn : 32'd0;
    end else if (state == MUL) begin
      if (cnt == 6'd0) prodReg <= $signed({32'd0, aMag} * {32'd0, bMag});
      else if (negP)   prodReg <= -prodReg;
    end else if (state == DIV) begin
      if (!remDiff[32]) begin
        remReg <= remDiff[31:0];
        quoReg <= {quoReg[30:0], 1'b1};
      end else begin
        remReg <= remShift[31:0];
        quoReg <= {quoReg[30:0], 1'b0};
      end
    end
  end

  // HI/LO result registers: change only on the write strobe or reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (hilo_we) begin
      if (isDiv) {hi, lo} <= divFixup(quoReg, remReg, negQ, negR, divZero, aRaw);
      else       {hi, lo} <= prodReg;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized
// operations against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, flushE;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall_req, hilo_we;
  logic [31:0] hi, lo;

  int testsRun = 0;
  int failed   = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flushE(flushE), .stall_req(stall_req), .hilo_we(hilo_we), .hi(hi), .lo(lo)
  );

  function automatic longint absVal(input logic [31:0] x, input bit sgn);
    longint v;
    v = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    return (v < 0) ? -v : v;
  endfunction

  // Cycles from acceptance to the write strobe
  function automatic int expLat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[1]) return 3;
`ifdef MULDIV_EARLY_OUT_EN
    if (y == 32'd0 || absVal(x, !o[0]) < absVal(y, !o[0])) return 1;
`endif
    return 33;
  endfunction

  // Expected {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; res = p; end
      2'b01: res = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Drives one op (start held while in E) and reports what was observed
  task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int doneCyc, output bit stallOk,
                       output logic [31:0] hiObs, output logic [31:0] loObs);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    doneCyc = -1;
    stallOk = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (hilo_we === 1'b1) begin
        doneCyc = c;
        if (stall_req !== 1'b0) stallOk = 1'b0;
        break;
      end
      if (stall_req !== 1'b1) stallOk = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    hiObs = hi;
    loObs = lo;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flushE = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++; if (stall_req !== 1'b0) begin failed++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    testsRun++; if (hilo_we !== 1'b0) begin failed++; $display("FAIL reset_we: got %b want 0", hilo_we); end
    testsRun++; if (hi !== 32'd0) begin failed++; $display("FAIL reset_hi: got %h want 0", hi); end
    testsRun++; if (lo !== 32'd0) begin failed++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_mul;
    int d; bit s; logic [31:0] h, l;
    @(posedge clk); #1;
    runOp(2'b01, 32'hFFFF_FFFF, 32'd2, d, s, h, l);
    testsRun++; if (d !== 3) begin failed++; $display("FAIL multu_latency: got %0d want 3", d); end
    testsRun++; if (s !== 1'b1) begin failed++; $display("FAIL multu_stall: stall pattern wrong"); end
    testsRun++; if (h !== 32'h1) begin failed++; $display("FAIL multu_hi: got %h want 00000001", h); end
    testsRun++; if (l !== 32'hFFFF_FFFE) begin failed++; $display("FAIL multu_lo: got %h want fffffffe", l); end
  endtask

  task automatic test_back_to_back;
    int d; bit s; logic [31:0] h, l, x, y; logic [63:0] e;
    @(posedge clk); #1;
    runOp(2'b00, 32'hFFFF_FFFD, 32'd5, d, s, h, l);
    testsRun++; if (d !== 3) begin failed++; $display("FAIL mult_latency: got %0d want 3", d); end
    testsRun++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFF1) begin failed++; $display("FAIL mult_neg: got %h%h want ffffffff_fffffff1", h, l); end
    // second MULT presented in the cycle right after DONE
    x = $urandom; y = $urandom;
    e = model(2'b00, x, y);
    runOp(2'b00, x, y, d, s, h, l);
    testsRun++; if (s !== 1'b1) begin failed++; $display("FAIL b2b_accept: second op not stalled/accepted at once"); end
    testsRun++; if (d !== 3) begin failed++; $display("FAIL b2b_latency: got %0d want 3", d); end
    testsRun++; if ({h, l} !== e) begin failed++; $display("FAIL b2b_result: got %h%h want %h", h, l, e); end
  endtask

  task automatic test_div;
    int d; bit s; logic [31:0] h, l;
    @(posedge clk); #1;
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, d, s, h, l);
    testsRun++; if (d !== 33) begin failed++; $display("FAIL div_latency: got %0d want 33", d); end
    testsRun++; if (s !== 1'b1) begin failed++; $display("FAIL div_stall: stall pattern wrong"); end
    testsRun++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failed++; $display("FAIL div_neg: got %h_%h want ffffffff_fffffffd", h, l); end
    runOp(2'b11, 32'h1234, 32'd0, d, s, h, l);
    testsRun++; if (d !== DZ_LAT) begin failed++; $display("FAIL divz_latency: got %0d want %0d", d, DZ_LAT); end
    testsRun++; if ({h, l} !== {32'h1234, 32'hFFFF_FFFF}) begin failed++; $display("FAIL divz_result: got %h_%h want 00001234_ffffffff", h, l); end
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, d, s, h, l);
    testsRun++; if ({h, l} !== {32'd0, 32'h8000_0000}) begin failed++; $display("FAIL div_ovf: got %h_%h want 00000000_80000000", h, l); end
    runOp(2'b10, 32'hFFFF_FFF0, 32'd0, d, s, h, l);
    testsRun++; if ({h, l} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF}) begin failed++; $display("FAIL sdivz_result: got %h_%h want fffffff0_ffffffff", h, l); end
  endtask

  task automatic test_flush;
    int d; bit s, weSeen; logic [31:0] h, l;
    @(posedge clk); #1;
    runOp(2'b11, 32'h2211, 32'h100, d, s, h, l);
    testsRun++; if ({h, l} !== {32'h11, 32'h22}) begin failed++; $display("FAIL flush_preload: got %h_%h want 00000011_00000022", h, l); end
    // DIVU 100/7 killed by flushE at T+10
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    weSeen = 1'b0;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (hilo_we === 1'b1) weSeen = 1'b1; end
    flushE = 1'b1;
    @(posedge clk); #1;
    flushE = 1'b0; start = 1'b0;
    #1;
    testsRun++; if (stall_req !== 1'b0) begin failed++; $display("FAIL flush_stall: got %b want 0 at T+11", stall_req); end
    for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (hilo_we === 1'b1) weSeen = 1'b1; end
    testsRun++; if (weSeen !== 1'b0) begin failed++; $display("FAIL flush_we: got write strobe want none"); end
    testsRun++; if ({hi, lo} !== {32'h11, 32'h22}) begin failed++; $display("FAIL flush_hilo: got %h_%h want 00000011_00000022", hi, lo); end
    // MULTU killed while in DONE
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    repeat (3) begin @(posedge clk); #1; end
    flushE = 1'b1;
    #1;
    testsRun++; if (hilo_we !== 1'b0) begin failed++; $display("FAIL flush_done_we: got %b want 0", hilo_we); end
    @(posedge clk); #1;
    flushE = 1'b0; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    testsRun++; if ({hi, lo} !== {32'h11, 32'h22}) begin failed++; $display("FAIL flush_done_hilo: got %h_%h want 00000011_00000022", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int d; bit s; logic [31:0] h, l;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = $urandom; b = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1; start = 1'b0;
    #1;
    testsRun++; if ({stall_req, hilo_we} !== 2'b00) begin failed++; $display("FAIL rstmid_ctrl: got stall=%b we=%b want 0 0", stall_req, hilo_we); end
    testsRun++; if ({hi, lo} !== 64'd0) begin failed++; $display("FAIL rstmid_hilo: got %h_%h want 0_0", hi, lo); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    runOp(2'b11, 32'd9, 32'd4, d, s, h, l);
    testsRun++; if ({h, l} !== {32'd1, 32'd2}) begin failed++; $display("FAIL rstmid_divu: got %h_%h want 00000001_00000002", h, l); end
  endtask

  task automatic test_random;
    int d; bit s; logic [31:0] h, l, x, y; logic [1:0] o; logic [63:0] e; int lat;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = $urandom_range(1, 300);
        2: y = (x >> $urandom_range(0, 31)) + 32'd1;
        default: y = $urandom;
      endcase
      if (i == 0) x = 32'd5;
      e = model(o, x, y);
      lat = expLat(o, x, y);
      runOp(o, x, y, d, s, h, l);
      testsRun++; if (d !== lat) begin failed++; $display("FAIL rand%0d_latency: op=%0d got %0d want %0d", i, o, d, lat); end
      testsRun++; if (s !== 1'b1) begin failed++; $display("FAIL rand%0d_stall: op=%0d stall pattern wrong", i, o); end
      testsRun++; if ({h, l} !== e) begin failed++; $display("FAIL rand%0d_result: op=%0d a=%h b=%h got %h%h want %h", i, o, x, y, h, l, e); end
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_back_to_back;
    test_div;
    test_flush;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule
